// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with shift-add multiply; optional divide under SEQ_ALU_DIV_EN
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [2:0]       cmp_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SET = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1111;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    // opnd_r: multiplicand (MUL) or divisor (DIV); work_lo: multiplier / dividend shift register
    logic [WIDTH-1:0] opnd_r, work_hi, work_lo;
    logic [WIDTH-1:0] result_r, hi_r;
    logic             zero_r, cout_r, ovf_r;

    logic             accept, iterating, last_step;
    logic [WIDTH-1:0] b_eff, alu_res;
    logic [WIDTH:0]   sum;
    logic             is_sub, lt, eq, set_flag, alu_cout, alu_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
`endif

    assign accept    = (state == S_IDLE) && start_i;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
`ifdef SEQ_ALU_DIV_EN
    assign iterating = (state == S_MUL) || (state == S_DIV);
`else
    assign iterating = (state == S_MUL);
`endif

    // Single-cycle ops evaluated straight from the inputs so the result lands on the accept edge
    always_comb begin
        is_sub   = (ctrl_i == OP_SUB);
        b_eff    = is_sub ? ~src2_i : src2_i;
        sum      = {1'b0, src1_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        lt       = $signed(src1_i) < $signed(src2_i);
        eq       = (src1_i == src2_i);
        case (cmp_i)
            3'b001:  set_flag = !lt && !eq;
            3'b010:  set_flag = lt || eq;
            3'b011:  set_flag = !lt;
            3'b110:  set_flag = eq;
            3'b100:  set_flag = !eq;
            default: set_flag = lt;
        endcase
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (ctrl_i)
            OP_AND: alu_res = src1_i & src2_i;
            OP_OR:  alu_res = src1_i | src2_i;
            OP_NOR: alu_res = ~(src1_i | src2_i);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (src1_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SET: alu_res = {{(WIDTH-1){1'b0}}, set_flag};
            default: alu_res = '0;
        endcase
    end

    // One iteration step: shift-add for MUL, restoring subtract for DIV
    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_shift = {work_hi, work_lo[WIDTH-1]};
        // Only used when the partial remainder is >= divisor, so the true difference fits WIDTH bits
        div_sub   = div_shift[WIDTH-1:0] - opnd_r;
        if (state == S_DIV) begin
            if (div_shift >= {1'b0, opnd_r}) begin
                step_hi = div_sub;
                step_lo = {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n = state;
        ready_o = 1'b0;
        done_o  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    if (ctrl_i == OP_MUL) state_n = S_MUL;
`ifdef SEQ_ALU_DIV_EN
                    else if (ctrl_i == OP_DIV) state_n = S_DIV;
`endif
                    else state_n = S_DONE;
                end
            end
            S_MUL: if (last_step) state_n = S_DONE;
`ifdef SEQ_ALU_DIV_EN
            S_DIV: if (last_step) state_n = S_DONE;
`endif
            S_DONE: begin
                done_o  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    // Operand capture on accept and iterative datapath update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            opnd_r  <= '0;
            work_hi <= '0;
            work_lo <= '0;
        end else if (accept) begin
            cnt     <= '0;
            work_hi <= '0;
            opnd_r  <= src1_i;
            work_lo <= src2_i;
`ifdef SEQ_ALU_DIV_EN
            if (ctrl_i == OP_DIV) begin
                opnd_r  <= src2_i;
                work_lo <= src1_i;
            end
`endif
        end else if (iterating) begin
            cnt     <= cnt + CNT_W'(1);
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    // Result registers, written only on the edge that enters DONE and held otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_r <= '0;
            hi_r     <= '0;
            zero_r   <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (accept && (state_n == S_DONE)) begin
            result_r <= alu_res;
            hi_r     <= '0;
            zero_r   <= (alu_res == '0);
            cout_r   <= alu_cout;
            ovf_r    <= alu_ovf;
        end else if (iterating && last_step) begin
            result_r <= step_lo;
            hi_r     <= step_hi;
            zero_r   <= (step_lo == '0);
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end
    end

    assign result_o   = result_r;
    assign hi_o       = hi_r;
    assign zero_o     = zero_r;
    assign cout_o     = cout_r;
    assign overflow_o = ovf_r;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking randomized bench for seq_alu against a behavioural model
`timescale 1ns/1ps
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   ctrl;
    logic [2:0]   cmp;
    logic [W-1:0] src1, src2;
    logic         ready, done, zero, cout, ovf;
    logic [W-1:0] result, hi;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl), .cmp_i(cmp),
        .src1_i(src1), .src2_i(src2), .ready_o(ready), .done_o(done),
        .result_o(result), .hi_o(hi), .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: what an op must produce, from plain arithmetic
    function automatic void ref_op(input logic [3:0] c, input logic [2:0] m,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output int lat, output logic [W-1:0] res,
                                   output logic [W-1:0] h, output logic co, output logic ov);
        longint sa, sb, d;
        logic [63:0] p;
        bit f;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = 1; res = '0; h = '0; co = 1'b0; ov = 1'b0;
        case (c)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b1100: res = ~(a | b);
            4'b0010: begin
                res = a + b;
                d = sa + sb;
                co = ((64'(a) + 64'(b)) >> W) != 0;
                ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            4'b0110: begin
                res = a - b;
                d = sa - sb;
                co = (a >= b);
                ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            4'b0111: begin
                case (m)
                    3'b001:  f = sa > sb;
                    3'b010:  f = sa <= sb;
                    3'b011:  f = sa >= sb;
                    3'b110:  f = sa == sb;
                    3'b100:  f = sa != sb;
                    default: f = sa < sb;
                endcase
                res = {{(W-1){1'b0}}, f};
            end
            4'b1111: begin
                p = 64'(a) * 64'(b);
                res = p[W-1:0];
                h = p[2*W-1:W];
                lat = W + 1;
            end
`ifdef SEQ_ALU_DIV_EN
            4'b1011: begin
                lat = W + 1;
                if (b == '0) begin res = '1; h = a; end
                else begin res = a / b; h = a % b; end
            end
`endif
            default: ;
        endcase
    endfunction

    // Behavioural model: busy countdown plus held output values
    int           m_wait = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_res = '0, m_hi = '0;
    logic         m_zero = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] p_res, p_hi;
    logic         p_co, p_ov;
    int           p_lat;

    always @(posedge clk) begin
        bit was_ready;
        was_ready = (m_wait == 0) && !m_done;
        m_done = 1'b0;
        if (rst) begin
            m_wait = 0; m_res = '0; m_hi = '0; m_zero = 1'b0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_wait > 0 || (was_ready && start)) begin
            if (m_wait == 0) begin
                ref_op(ctrl, cmp, src1, src2, p_lat, p_res, p_hi, p_co, p_ov);
                m_wait = p_lat;
            end
            m_wait--;
            if (m_wait == 0) begin
                m_done = 1'b1;
                m_res = p_res; m_hi = p_hi; m_zero = (p_res == '0); m_cout = p_co; m_ovf = p_ov;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_o", 64'(ready), 64'((m_wait == 0) && !m_done));
            chk("done_o", 64'(done), 64'(m_done));
            chk("result_o", 64'(result), 64'(m_res));
            chk("hi_o", 64'(hi), 64'(m_hi));
            chk("zero_o", 64'(zero), 64'(m_zero));
            chk("cout_o", 64'(cout), 64'(m_cout));
            chk("overflow_o", 64'(ovf), 64'(m_ovf));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        if (!ready) chk("wait_ready_timeout", 64'(ready), 64'd1);
    endtask

    // Issue one op; optionally pulse start mid-op at step pulse_at; returns observed latency (-1 on timeout)
    task automatic do_op(input logic [3:0] c, input logic [2:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int pulse_at, output int lat_seen);
        int n;
        wait_ready();
        ctrl = c; cmp = m; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom); cmp = 3'($urandom);
        n = 1;
        while (!done && n < 100) begin
            start = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        lat_seen = done ? n : -1;
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_lit(input string name, input logic [3:0] c, input logic [2:0] m,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic [W-1:0] eh, input int el);
        int lat;
        do_op(c, m, a, b, 0, lat);
        chk({name, "_res"}, 64'(result), 64'(er));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lat"}, 64'(lat), 64'(el));
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] ops[10];
        int lat;
        bit saw_done;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b1011, 4'b0011, 4'b1001};

        // Reset with a simultaneous start request
        rst = 1'b1; start = 1'b1; ctrl = 4'b0010; cmp = 3'b000; src1 = 32'd1; src2 = 32'd2;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_flags", 64'({zero, cout, ovf}), 64'd0);
        saw_done = 1'b0;
        repeat (4) begin @(negedge clk); saw_done |= done; end
        chk("rst_no_done", 64'(saw_done), 64'd0);

        // Directed literal cases
        run_lit("add_ovf", 4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, '0, 1);
        chk("add_ovf_flag", 64'(ovf), 64'd1);
        chk("add_ovf_cout", 64'(cout), 64'd0);
        run_lit("sub_zero", 4'b0110, 3'b000, 32'd5, 32'd5, '0, '0, 1);
        chk("sub_zero_z", 64'(zero), 64'd1);
        chk("sub_zero_cout", 64'(cout), 64'd1);
        run_lit("slt", 4'b0111, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd1, '0, 1);
        run_lit("sgt", 4'b0111, 3'b001, 32'hFFFF_FFFF, 32'd1, 32'd0, '0, 1);
        run_lit("seq", 4'b0111, 3'b110, 32'd7, 32'd7, 32'd1, '0, 1);
        run_lit("sne", 4'b0111, 3'b100, 32'd7, 32'd7, 32'd0, '0, 1);
        run_lit("s111", 4'b0111, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, '0, 1);
        do_op(4'b1111, 3'b000, 32'hFFFF_FFFF, 32'd2, 12, lat);
        chk("mul_res", 64'(result), 64'hFFFF_FFFE);
        chk("mul_hi", 64'(hi), 64'd1);
        chk("mul_lat", 64'(lat), 64'd33);
`ifdef SEQ_ALU_DIV_EN
        run_lit("divu", 4'b1011, 3'b000, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_lit("div0", 4'b1011, 3'b000, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 33);
        chk("div0_zero", 64'(zero), 64'd0);
`else
        run_lit("unk1011", 4'b1011, 3'b000, 32'd100, 32'd7, 32'd0, 32'd0, 1);
`endif

        // Reset in the middle of a multiply
        wait_ready();
        ctrl = 4'b1111; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ready", 64'(ready), 64'd1);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_hi", 64'(hi), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); saw_done |= done; end
        chk("mrst_no_done", 64'(saw_done), 64'd0);
        run_lit("and", 4'b0000, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, '0, 1);

        // Randomized ops, checked cycle by cycle by the compare process
        for (int i = 0; i < 150; i++) begin
            do_op(ops[$urandom_range(0, 9)], 3'($urandom), rand_opnd(), rand_opnd(),
                  int'($urandom_range(0, 40)), lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU with multi-cycle unsigned multiply.
- Generalises the datapath width and compare modes of the combinational lab ALU.
- Adds a start/ready/done handshake so the CPU datapath can stall on long operations.
- Sits between the register file read stage and writeback. Operands are captured at accept, and results hold until the next completion.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted only on a cycle where ready_o=1.
- ctrl_i  input  4  operation select (encodings under Behaviour).
- cmp_i  input  3  compare mode for SET.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ready_o  output  1  block idle and able to accept.
- done_o  output  1  one-cycle pulse; result valid.
- result_o  output  WIDTH  result (low half for MUL).
- hi_o  output  WIDTH  upper half of product; 0 for other ops.
- zero_o  output  1  result_o==0.
- cout_o  output  1  adder carry out (ADD/SUB only).
- overflow_o  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (rst_i=1 at an edge):
  - State goes to IDLE.
  - ready_o=1, done_o=0.
  - result_o, hi_o, zero_o, cout_o and overflow_o all 0; counter cleared.
  - Reset wins over start_i on the same edge. Reset mid-MUL aborts the operation with no done_o pulse.
- ctrl_i encodings:
  - 0000 AND, 0001 OR, 1100 NOR.
  - 0010 ADD.
  - 0110 SUB (A + ~B + 1).
  - 0111 SET: result_o = {0…, flag}.
  - 1111 MUL.
  - Any other code: result_o=0, completes as a single-cycle op.
- SET flag by cmp_i (signed compare of A and B):
  - 000 A<B; 001 A>B; 010 A≤B; 011 A≥B; 110 A==B; 100 A≠B.
  - Other codes behave as 000.
- Accept: at an edge with ready_o=1 and start_i=1, operands, ctrl_i and cmp_i are registered internally. Later changes on the inputs have no effect on the running op.
- States:
  - IDLE: ready_o=1. On accept of a non-MUL op go to DONE; on accept of MUL go to MUL.
  - MUL: ready_o=0. Shift-add with one multiplier bit per cycle, LSB first, for exactly WIDTH cycles. The counter counts 0..WIDTH-1, then go to DONE.
  - DONE: the output registers are written on entry. done_o=1 for exactly this one cycle, ready_o=0. Always return to IDLE.
- Latency, accept edge to done_o high:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
  - Throughput: one op per 2 cycles minimum (a new accept is possible in the cycle after done_o).
- start_i while ready_o=0 is ignored, not queued.
- MUL is unsigned: {hi_o, result_o} = A*B, 2*WIDTH bits, no truncation.
- Flags:
  - cout_o: carry out of bit WIDTH-1 for ADD/SUB, otherwise 0.
  - overflow_o: (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is B for ADD and ~B for SUB. 0 for all other ops.
  - zero_o reflects result_o only (hi_o ignored).
- Outputs hold their last values between done pulses.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- When defined, ctrl_i=1011 is DIVU, an unsigned restoring divide over WIDTH iterations (state DIV, same latency as MUL): result_o = quotient, hi_o = remainder.
- Divide by zero: result_o all ones, hi_o = A, zero_o=0, completes at normal latency.
- When undefined, 1011 is an unknown code: result_o=0, single-cycle, no DIV state or divider logic synthesised.

Test Plan (WIDTH=32):
- Reset then idle: ready_o=1, done_o=0, all outputs 0. Assert start_i together with rst_i → no done_o afterwards.
- ADD 0x7FFFFFFF+0x00000001 → result_o=0x80000000, overflow_o=1, cout_o=0, done_o one cycle after accept. SUB 5-5 → result_o=0, zero_o=1, cout_o=1.
- SET signed: A=0xFFFFFFFF (-1), B=1:
  - cmp 000 → 1; cmp 001 → 0.
  - cmp 110 with A=B=7 → 1; cmp 100 with A=B=7 → 0.
  - cmp 111 with A=-1, B=1 → 1 (behaves as slt).
- MUL 0xFFFFFFFF*0x00000002:
  - result_o=0xFFFFFFFE, hi_o=0x00000001, done_o exactly 33 cycles after accept.
  - ready_o=0 throughout; start_i pulsed mid-op is ignored.
- Reset asserted at cycle 10 of a MUL → no done_o, outputs 0, ready_o=1 next cycle; a following AND 0xF0F0F0F0&0xFF00FF00 → 0xF000F000.
- With SEQ_ALU_DIV_EN: DIVU 100/7 → result_o=14, hi_o=2 after 33 cycles; 9/0 → result_o=0xFFFFFFFF, hi_o=9. Without the macro: 1011 → result_o=0 after 1 cycle.
